seq_divider_param: RTL

- Parametrised multi-cycle restoring divider.
- Successor to the fixed 9-bit divider: width set by parameter, optional signed (two's-complement) mode, divide-by-zero and signed-overflow flags, one-cycle done pulse.
- Produces one quotient bit per clock.
- Sits on the datapath bus between operand registers (Abus/Bbus) and result registers (Qbus/Rbus). Uses the same start/ready handshake as the existing dividers.

---
 rtl/seq_divider_pkg.sv | 24 ++
 rtl/seq_divider_param_div_step.sv | 23 ++
 rtl/seq_divider_param.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the parametrised sequential divider:
// FSM state encoding and a constant-evaluable ceil(log2) helper.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Bits needed to hold values 0..value-1 (at least 1).
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/seq_divider_param_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder and subtract the divisor magnitude if it fits.
module div_step #(
    parameter int W = 9
) (
    input  logic [W-1:0] p,
    input  logic         bit_in,
    input  logic [W-1:0] b_mag,
    output logic [W-1:0] p_next,
    output logic         q_bit
);

    logic [W:0] shifted;

    // Compare on W+1 bits so a partial remainder close to a large divisor never overflows.
    always_comb begin
        shifted = {p, bit_in};
        q_bit   = (shifted >= {1'b0, b_mag});
        // When the subtraction is taken the result is below b_mag, so it fits in W bits.
        p_next  = q_bit ? W'(shifted - {1'b0, b_mag}) : shifted[W-1:0];
    end

endmodule

// File: rtl/seq_divider_param.sv
// Parametrised multi-cycle restoring divider with optional two's-complement
// mode. One quotient bit per clock, divide-by-zero and signed-overflow flags,
// one-cycle done pulse, start/ready handshake.
module seq_divider_param
    import seq_divider_pkg::*;
#(
    parameter int W         = 9,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [W-1:0] Abus,
    input  logic [W-1:0] Bbus,
    output logic [W-1:0] Qbus,
    output logic [W-1:0] Rbus,
    output logic         ready,
    output logic         done,
    output logic         dbz,
    output logic         ovf
);

    localparam int           CW      = clog2(W);
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   dq;        // dividend magnitude shifting out, quotient shifting in
    logic [W-1:0]   p;         // partial remainder
    logic [W-1:0]   b_mag;
    logic           neg_q;
    logic           neg_r;
    logic           dbz_pend;
    logic           ovf_pend;

    logic           mode;
    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   a_abs;
    logic [W-1:0]   b_abs;
    logic [W-1:0]   p_step;
    logic           q_bit;

    // Operand sign decode and magnitudes; -2^(W-1) maps to 2^(W-1) unsigned.
    always_comb begin
        mode  = signed_mode & SIGNED_EN;
        a_neg = mode & Abus[W-1];
        b_neg = mode & Bbus[W-1];
        a_abs = a_neg ? -Abus : Abus;
        b_abs = b_neg ? -Bbus : Bbus;
    end

    div_step #(.W(W)) u_step (
        .p      (p),
        .bit_in (dq[W-1]),
        .b_mag  (b_mag),
        .p_next (p_step),
        .q_bit  (q_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = (Bbus == '0) ? ST_FIX : ST_CALC;
            ST_CALC: if (cnt == '0) state_next = ST_FIX;
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode: idle means result valid and a new start can be taken.
    always_comb begin
        ready = (state == ST_IDLE);
    end

    // Datapath: capture on accepted start, one restoring step per CALC cycle, sign fix-up and result write in FIX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            dq       <= '0;
            p        <= '0;
            b_mag    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dbz_pend <= 1'b0;
            ovf_pend <= 1'b0;
            Qbus     <= '0;
            Rbus     <= '0;
            done     <= 1'b0;
            dbz      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dbz      <= 1'b0;
                        ovf      <= 1'b0;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        dbz_pend <= (Bbus == '0);
                        ovf_pend <= mode && (Abus == MIN_VAL) && (Bbus == '1);
                        p        <= '0;
                        cnt      <= CW'(W - 1);
                        b_mag    <= b_abs;
                        // On divide-by-zero the raw dividend is kept so it can be returned as the remainder.
                        dq       <= (Bbus == '0) ? Abus : a_abs;
                    end
                end
                ST_CALC: begin
                    p   <= p_step;
                    dq  <= {dq[W-2:0], q_bit};
                    cnt <= cnt - CW'(1);
                end
                ST_FIX: begin
                    done <= 1'b1;
                    dbz  <= dbz_pend;
                    ovf  <= ovf_pend;
                    if (dbz_pend) begin
                        Qbus <= '1;
                        Rbus <= dq;
                    end else begin
                        // Truncating division: quotient sign from operand signs, remainder takes dividend sign.
                        Qbus <= neg_q ? -dq : dq;
                        Rbus <= neg_r ? -p : p;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
